// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage controller.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } memop_t;

  // Controller states; kept as plain constants so the state register is a bare vector.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int unsigned size_bytes(input logic [1:0] s);
    return 32'd1 << s;
  endfunction

  function automatic bit data_w_ok(input int w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane alignment: load extract + sign/zero extend, store strobe + lane shift.
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LO_W   = $clog2(DATA_W/8)
) (
  input  logic [LO_W-1:0]     lo,
  input  logic [1:0]          size,
  input  logic                uns,
  input  logic [DATA_W-1:0]   rraw,
  input  logic [DATA_W-1:0]   wsrc,
  output logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] strobe
);

  localparam int NB = DATA_W/8;

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] keep;
  logic              sgn;
  logic [NB-1:0]     base;

  // Load path: shift lane down, keep the sized field, fill the rest with sign or zero.
  always_comb begin
    sh   = rraw >> {lo, 3'b000};
    keep = '1;
    sgn  = 1'b0;
    case (size)
      SZ_B: begin keep = DATA_W'(8'hFF);         sgn = sh[7];  end
      SZ_H: begin keep = DATA_W'(16'hFFFF);      sgn = sh[15]; end
      SZ_W: begin keep = DATA_W'(32'hFFFF_FFFF); sgn = sh[31]; end
      default: begin keep = '1;                  sgn = 1'b0;   end
    endcase
    rdata = (sh & keep) | ({DATA_W{sgn & ~uns}} & ~keep);
  end

  // Store path: byte-enable mask and data moved up to the addressed lane.
  always_comb begin
    case (size)
      SZ_B:    base = NB'(8'h01);
      SZ_H:    base = NB'(8'h03);
      SZ_W:    base = NB'(8'h0F);
      default: base = NB'(8'hFF);
    endcase
    strobe = base << lo;
    wdata  = wsrc << {lo, 3'b000};
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: one op at a time, hold-until-accepted bus request,
// registered result to writeback with accept-through on out_ready.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 128
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                dreq_valid,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic [1:0]          dreq_size,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_fault
);

  localparam int LO_W = $clog2(DATA_W/8);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("mem_stage_ctrl: DATA_W must be 32 or 64");
  end

  logic [1:0]        state;
  logic              kill;
  logic [1:0]        op_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [TAG_W-1:0]  tag_q;
  logic              fault_q;
  logic [DATA_W-1:0] res_q;

  logic              acc, in_mem, in_mis, in_fault, busy, resp_done, kill_now;
  logic [1:0]        acc_state;
  logic [DATA_W-1:0] ld_data, st_data;
  logic [DATA_W/8-1:0] st_strobe;

  // Accept decode and alignment check on the incoming op.
  always_comb begin
    busy      = (state == ST_REQ) || (state == ST_WAIT);
    in_ready  = !kill && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    acc       = in_valid && in_ready && !flush;
    in_mem    = (in_op == OP_LOAD) || (in_op == OP_STORE);
    in_mis    = |(in_addr[LO_W-1:0] & LO_W'(size_bytes(in_size) - 32'd1))
                || ((DATA_W == 32) && (in_size == SZ_D));
    in_fault  = in_mem && in_mis;
    acc_state = (in_mem && !in_mis) ? ST_REQ : ST_DONE;
    resp_done = ((state == ST_REQ) && dresp_addr_ok && dresp_data_ok)
             || ((state == ST_WAIT) && dresp_data_ok);
    kill_now  = kill || flush;
  end

  mem_align #(.DATA_W(DATA_W)) u_align (
    .lo     (addr_q[LO_W-1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .rraw   (dresp_data),
    .wsrc   (wdata_q),
    .rdata  (ld_data),
    .wdata  (st_data),
    .strobe (st_strobe)
  );

  // Control FSM and the kill flag for a flushed in-flight bus transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      kill  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (acc) state <= acc_state;
        ST_REQ: begin
          if (dresp_addr_ok && dresp_data_ok) state <= kill_now ? ST_IDLE : ST_DONE;
          else if (dresp_addr_ok)             state <= ST_WAIT;
        end
        ST_WAIT: if (dresp_data_ok) state <= kill_now ? ST_IDLE : ST_DONE;
        default: begin
          if (flush)          state <= ST_IDLE;
          else if (out_ready) state <= acc ? acc_state : ST_IDLE;
        end
      endcase
      if (resp_done)          kill <= 1'b0;
      else if (flush && busy) kill <= 1'b1;
    end
  end

  // Op latch on accept; load result overwrites the address once data returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      fault_q <= 1'b0;
      res_q   <= '0;
    end else if (acc) begin
      op_q    <= in_op;
      size_q  <= in_size;
      uns_q   <= in_unsigned;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      tag_q   <= in_tag;
      fault_q <= in_fault;
      res_q   <= DATA_W'(in_addr);
    end else if (resp_done && (op_q == OP_LOAD) && !kill_now) begin
      res_q   <= ld_data;
    end
  end

  // Bus and writeback outputs come straight from latched state.
  always_comb begin
    dreq_valid  = (state == ST_REQ);
    dreq_addr   = addr_q;
    dreq_size   = size_q;
    dreq_strobe = (op_q == OP_STORE) ? st_strobe : '0;
    dreq_data   = (op_q == OP_STORE) ? st_data : '0;
    out_valid   = (state == ST_DONE);
    out_rdata   = res_q;
    out_tag     = tag_q;
    out_fault   = fault_q;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl at DATA_W=64.
module tb_mem_stage_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int TAG_W  = 128;

  logic                clk = 1'b0;
  logic                resetn;
  logic                in_valid, in_ready;
  logic [1:0]          in_op, in_size;
  logic                in_unsigned;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic [TAG_W-1:0]    in_tag;
  logic                flush;
  logic                dreq_valid;
  logic [ADDR_W-1:0]   dreq_addr;
  logic [1:0]          dreq_size;
  logic [DATA_W/8-1:0] dreq_strobe;
  logic [DATA_W-1:0]   dreq_data;
  logic                dresp_addr_ok, dresp_data_ok;
  logic [DATA_W-1:0]   dresp_data;
  logic                out_valid, out_ready;
  logic [DATA_W-1:0]   out_rdata;
  logic [TAG_W-1:0]    out_tag;
  logic                out_fault;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_tag(out_tag), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wd, input logic [127:0] tg);
    in_valid    = 1'b1;
    in_op       = op;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wd;
    in_tag      = tg;
  endtask

  // Accept an op, answer addr_ok+data_ok in the first REQ cycle, land in DONE.
  task automatic load_fast(input logic [1:0] sz, input logic uns, input logic [63:0] addr,
                           input logic [63:0] rd, input logic [127:0] tg);
    send(2'd1, sz, uns, addr, 64'h0, tg);
    tick();
    in_valid      = 1'b0;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = rd;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; in_valid = 1'b0; in_op = '0; in_size = '0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; in_tag = '0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b0;
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,    1);
    chk("rst_out_valid", out_valid,   0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_out_rdata", out_rdata,   0);
    chk("rst_strobe",    dreq_strobe, 0);
    chk("rst_fault",     out_fault,   0);
    resetn = 1'b1;
    tick();

    // Load dword, same-cycle addr_ok/data_ok.
    send(2'd1, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 128'hA1);
    tick();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h8877_6655_4433_2211;
    #1;
    chk("ld_d_dreq_valid", dreq_valid, 1);
    chk("ld_d_dreq_addr",  dreq_addr,  64'h8000_0008);
    chk("ld_d_dreq_size",  dreq_size,  3);
    chk("ld_d_strobe",     dreq_strobe, 0);
    chk("ld_d_out_valid_early", out_valid, 0);
    chk("ld_d_in_ready",   in_ready,   0);
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    chk("ld_d_out_valid", out_valid, 1);
    chk("ld_d_rdata",     out_rdata, 64'h8877_6655_4433_2211);
    chk("ld_d_fault",     out_fault, 0);
    chk("ld_d_tag",       out_tag,   128'hA1);
    retire();
    chk("ld_d_idle", out_valid, 0);

    // Signed / unsigned byte at lane 3.
    load_fast(2'd0, 1'b0, 64'h8000_0003, 64'h0000_0000_80FF_0000, 128'hA2);
    chk("ld_b_s_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    retire();
    load_fast(2'd0, 1'b1, 64'h8000_0003, 64'h0000_0000_80FF_0000, 128'hA3);
    chk("ld_b_u_rdata", out_rdata, 64'h0000_0000_0000_0080);
    retire();

    // Signed half at lane 6, signed word at lane 4.
    load_fast(2'd1, 1'b0, 64'h8000_0006, 64'h8001_0000_0000_0000, 128'hA4);
    chk("ld_h_s_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_8001);
    retire();
    load_fast(2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF_0000_0000, 128'hA5);
    chk("ld_w_s_rdata", out_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    retire();

    // Store half at lane 6 with addr_ok held off for 3 cycles.
    send(2'd2, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 128'hB1);
    tick();
    in_valid = 1'b1; in_addr = 64'h1234_5671; in_wdata = 64'h5555; in_size = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_h_dreq_valid", dreq_valid, 1);
      chk("st_h_strobe",     dreq_strobe, 8'hC0);
      chk("st_h_data",       dreq_data,  64'hBEEF_0000_0000_0000);
      chk("st_h_addr",       dreq_addr,  64'h8000_0006);
      chk("st_h_size",       dreq_size,  1);
      tick();
    end
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    chk("st_h_wait_dreq", dreq_valid, 0);
    chk("st_h_wait_out",  out_valid,  0);
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk("st_h_out_valid", out_valid, 1);
    chk("st_h_rdata",     out_rdata, 64'h8000_0006);
    chk("st_h_fault",     out_fault, 0);
    retire();

    // Misaligned word load: no bus request, fault next cycle.
    send(2'd1, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 128'hC1);
    tick();
    in_valid = 1'b0;
    chk("mis_dreq_valid", dreq_valid, 0);
    chk("mis_out_valid",  out_valid,  1);
    chk("mis_fault",      out_fault,  1);
    chk("mis_rdata",      out_rdata,  64'h8000_0002);
    retire();

    // Flush in REQ: addr_ok at +2, data_ok at +4, result discarded.
    send(2'd1, 2'd3, 1'b0, 64'h0000_0100, 64'h0, 128'hD1);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_req_dreq0", dreq_valid, 1);
    tick();
    flush = 1'b0;
    chk("fl_req_dreq1", dreq_valid, 1);
    chk("fl_req_in_ready", in_ready, 0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    chk("fl_wait_dreq", dreq_valid, 0);
    chk("fl_wait_out",  out_valid,  0);
    tick();
    chk("fl_wait_out2", out_valid, 0);
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    dresp_data_ok = 1'b0; dresp_data = '0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready",  in_ready,  1);

    // Bypass held in DONE for 4 cycles, then accept-through of a second bypass.
    send(2'd0, 2'd3, 1'b0, 64'h0000_0000_0000_5000, 64'h0, 128'hE1);
    tick();
    chk("byp_out_valid", out_valid, 1);
    chk("byp_fault",     out_fault, 0);
    send(2'd0, 2'd0, 1'b0, 64'h0000_0000_0000_6000, 64'h0, 128'hE2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_rdata",     out_rdata, 64'h5000);
      chk("hold_tag",       out_tag,   128'hE1);
      chk("hold_in_ready",  in_ready,  0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("thru_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("thru_out_valid", out_valid, 1);
    chk("thru_rdata",     out_rdata, 64'h6000);
    chk("thru_tag",       out_tag,   128'hE2);
    retire();
    chk("thru_idle", out_valid, 0);

    // Flush in DONE drops the result.
    send(2'd0, 2'd0, 1'b0, 64'h7000, 64'h0, 128'hF1);
    tick();
    in_valid = 1'b0;
    chk("fl_done_pre", out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_done_out_valid", out_valid, 0);

    // Flush with in_valid in IDLE: no accept.
    send(2'd0, 2'd0, 1'b0, 64'h7100, 64'h0, 128'hF2);
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fl_idle_no_acc", out_valid, 0);

    // Reserved op behaves as bypass.
    send(2'd3, 2'd0, 1'b0, 64'h40, 64'h0, 128'hF3);
    tick();
    in_valid = 1'b0;
    chk("rsvd_dreq",  dreq_valid, 0);
    chk("rsvd_valid", out_valid,  1);
    chk("rsvd_rdata", out_rdata,  64'h40);
    chk("rsvd_fault", out_fault,  0);
    retire();

    // Misaligned word store: strobe path never reaches the bus.
    send(2'd2, 2'd2, 1'b0, 64'h8000_0001, 64'h1122_3344, 128'hF4);
    tick();
    in_valid = 1'b0;
    chk("st_mis_dreq",  dreq_valid, 0);
    chk("st_mis_fault", out_fault,  1);
    retire();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
